wb_rr_arbiter: RTL and testbench

//  Round-robin Wishbone arbiter: shares one slave port (wb_slave_adapter -> memory)

---
 rtl/wb_rr_arbiter_pkg.sv | 16 +
 rtl/wb_rr_arbiter_if.sv | 54 +++++
 rtl/wb_rr_arbiter_pick.sv | 31 +++
 rtl/wb_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types for the round-robin Wishbone arbiter.
// FSM state encoding plus index-width and watchdog-width helpers.
package wb_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int WD_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N Wishbone masters, the arbiter and one slave.
// The arbiter uses the slave modport; the environment uses master.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS*AW-1:0]     m_adr_i;
  logic [NUM_MASTERS*DW-1:0]     m_dat_i;
  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i;
  logic [NUM_MASTERS-1:0]        m_we_i;
  logic [NUM_MASTERS-1:0]        m_cyc_i;
  logic [NUM_MASTERS-1:0]        m_stb_i;
  logic [DW-1:0]                 m_dat_o;
  logic [NUM_MASTERS-1:0]        m_ack_o;
  logic [NUM_MASTERS-1:0]        m_err_o;
  logic [NUM_MASTERS-1:0]        m_stall_o;
  logic [AW-1:0]                 s_adr_o;
  logic [DW-1:0]                 s_dat_o;
  logic [DW/8-1:0]               s_sel_o;
  logic                          s_we_o;
  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic [DW-1:0]                 s_dat_i;
  logic                          s_ack_i;
  logic                          s_err_i;
  logic                          s_stall_i;
  logic [NUM_MASTERS-1:0]        grant_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i,
    input  m_we_i, m_cyc_i, m_stb_i,
    input  s_dat_i, s_ack_i, s_err_i,
    input  s_stall_i,
    output m_dat_o, m_ack_o, m_err_o,
    output m_stall_o,
    output s_adr_o, s_dat_o, s_sel_o,
    output s_we_o, s_cyc_o, s_stb_o,
    output grant_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i,
    output m_we_i, m_cyc_i, m_stb_i,
    output s_dat_i, s_ack_i, s_err_i,
    output s_stall_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  m_stall_o,
    input  s_adr_o, s_dat_o, s_sel_o,
    input  s_we_o, s_cyc_o, s_stb_o,
    input  grant_o
  );

endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Rotating-priority picker: first requester above last wins.
// Purely combinational; one-hot winner, its index and a valid flag.
module wb_rr_pick #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [LW-1:0] idx,
  output logic          vld
);

  // scan last+1 .. last+N (mod N), keep the first hit
  always_comb begin
    logic [LW-1:0] k;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    k   = '0;
    for (int i = 1; i <= N; i++) begin
      k = LW'((int'(last) + i) % N);
      if (!vld && req[k]) begin
        vld    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter, grant held for a whole bus cycle.
// Optional watchdog: define WB_ARB_TIMEOUT_EN (uses TIMEOUT_CYC).
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic          clk,
  input  logic          rst,
  wb_rr_arbiter_if.slave bus
);

  localparam int N  = NUM_MASTERS;
  localparam int LW = idx_w(N);
  localparam int SW = DW / 8;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [LW-1:0] last_q, last_d;

  logic [N-1:0]  pick_gnt;
  logic [LW-1:0] pick_idx;
  logic          pick_vld;

  logic busy;
  logic own_cyc;
  logic stb_en;
  logic to_hit;

  assign busy    = (state_q == ST_BUSY);
  assign own_cyc = bus.m_cyc_i[last_q];

  wb_rr_pick #(
    .N  (N),
    .LW (LW)
  ) u_pick (
    .req  (bus.m_cyc_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

`ifdef WB_ARB_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;

  assign stb_en = ~to_q;

  // watchdog counts unanswered strobe cycles of the owner
  always_comb begin
    wd_d   = wd_q;
    to_d   = to_q;
    to_hit = 1'b0;
    if (!busy) begin
      wd_d = '0;
      to_d = 1'b0;
    end else if (bus.s_ack_i || bus.s_err_i) begin
      wd_d = '0;
    end else if (bus.s_stb_o) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
        to_hit = 1'b1;
        to_d   = 1'b1;
        wd_d   = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end
`else
  assign stb_en = 1'b1;
  assign to_hit = 1'b0;
`endif

  // owner mux onto the slave and response routing back
  always_comb begin
    bus.s_adr_o   = '0;
    bus.s_dat_o   = '0;
    bus.s_sel_o   = '0;
    bus.s_we_o    = 1'b0;
    bus.s_cyc_o   = 1'b0;
    bus.s_stb_o   = 1'b0;
    bus.m_ack_o   = '0;
    bus.m_err_o   = '0;
    bus.m_stall_o = '1;
    if (busy) begin
      bus.s_adr_o = bus.m_adr_i[int'(last_q)*AW +: AW];
      bus.s_dat_o = bus.m_dat_i[int'(last_q)*DW +: DW];
      bus.s_sel_o = bus.m_sel_i[int'(last_q)*SW +: SW];
      bus.s_we_o  = own_cyc & bus.m_we_i[last_q];
      bus.s_cyc_o = own_cyc;
      bus.s_stb_o = own_cyc & bus.m_stb_i[last_q] & stb_en;
      bus.m_ack_o[last_q]   = bus.s_ack_i;
      bus.m_err_o[last_q]   = bus.s_err_i | to_hit;
      bus.m_stall_o[last_q] = bus.s_stall_i;
    end
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant_q;

  // arbitration FSM next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          last_d  = pick_idx;
          state_d = ST_BUSY;
        end
      end
      (state_q == ST_BUSY): begin
        if (!own_cyc) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // FSM registers; last_q points at master N-1 so master 0 wins first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with 4 masters and a memory slave.
// Watchdog steps only run when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_rr_arbiter;

  logic clk;
  logic rst;
  int   npass;
  int   ntot;

  logic        ack_en;
  logic        force_ack;
  logic        slv_err;
  logic [31:0] mem [0:255];

  wb_rr_arbiter_if #(.NUM_MASTERS(4), .AW(32), .DW(32)) bus ();

`ifdef WB_ARB_TIMEOUT_EN
  wb_rr_arbiter #(
    .NUM_MASTERS (4),
    .AW          (32),
    .DW          (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`else
  wb_rr_arbiter #(
    .NUM_MASTERS (4),
    .AW          (32),
    .DW          (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.s_ack_i   = (bus.s_cyc_o & bus.s_stb_o & ack_en) | force_ack;
  assign bus.s_err_i   = slv_err;
  assign bus.s_stall_i = 1'b0;
  assign bus.s_dat_i   = mem[bus.s_adr_o[9:2]];

  always @(posedge clk) begin
    if (bus.s_cyc_o && bus.s_stb_o && bus.s_we_o && ack_en)
      mem[bus.s_adr_o[9:2]] <= bus.s_dat_o;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb,
                       input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[k]         = cyc;
    bus.m_stb_i[k]         = stb;
    bus.m_we_i[k]          = 1'b1;
    bus.m_adr_i[k*32 +: 32] = adr;
    bus.m_dat_i[k*32 +: 32] = dat;
    bus.m_sel_i[k*4 +: 4]  = 4'hF;
  endtask

  initial begin
    npass     = 0;
    ntot      = 0;
    rst       = 1'b0;
    ack_en    = 1'b1;
    force_ack = 1'b0;
    slv_err   = 1'b0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_we_i  = '0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;

    nxt();
    nxt();
    @(negedge clk);
    chk("rst_grant", 32'(bus.grant_o), 32'h0);
    chk("rst_scyc", 32'(bus.s_cyc_o), 32'h0);
    chk("rst_stall", 32'(bus.m_stall_o), 32'hF);
    chk("rst_ack", 32'(bus.m_ack_o), 32'h0);
    chk("rst_err", 32'(bus.m_err_o), 32'h0);
    nxt();
    rst = 1'b1;

    // single write by m0
    set_m(0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_lat_grant", 32'(bus.grant_o), 32'h0);
    chk("t1_lat_scyc", 32'(bus.s_cyc_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("t1_grant", 32'(bus.grant_o), 32'h1);
    chk("t1_sadr", bus.s_adr_o, 32'h40);
    chk("t1_ack", 32'(bus.m_ack_o), 32'h1);
    chk("t1_stall", 32'(bus.m_stall_o), 32'hE);
    nxt();
    set_m(0, 1'b0, 1'b0, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_drop_scyc", 32'(bus.s_cyc_o), 32'h0);
    chk("t1_drop_grant", 32'(bus.grant_o), 32'h1);
    nxt();
    @(negedge clk);
    chk("t1_idle_grant", 32'(bus.grant_o), 32'h0);
    chk("t1_mem", mem[8'h10], 32'hDEADBEEF);
    force_ack = 1'b1;
    #1;
    chk("idle_ack_drop", 32'(bus.m_ack_o), 32'h0);
    force_ack = 1'b0;

    // reset pulse, then all four request together
    nxt();
    rst = 1'b0;
    nxt();
    rst = 1'b1;
    for (int k = 0; k < 4; k++)
      set_m(k, 1'b1, 1'b1, 32'h100 + 32'(4*k), 32'hA0 + 32'(k));
    @(negedge clk);
    chk("t2_start_grant", 32'(bus.grant_o), 32'h0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      @(negedge clk);
      chk("t2_grant", 32'(bus.grant_o), 32'(1 << k));
      chk("t2_sadr", bus.s_adr_o, 32'h100 + 32'(4*k));
      nxt();
      set_m(k, 1'b0, 1'b0, 32'h100 + 32'(4*k), 32'hA0 + 32'(k));
      @(negedge clk);
      chk("t2_drop_scyc", 32'(bus.s_cyc_o), 32'h0);
      nxt();
      @(negedge clk);
      chk("t2_idle_grant", 32'(bus.grant_o), 32'h0);
    end
    for (int k = 0; k < 4; k++)
      chk("t2_mem", mem[8'h40 + 8'(k)], 32'hA0 + 32'(k));

    // m2 holds the bus for three writes while m1 waits
    set_m(2, 1'b1, 1'b1, 32'h200, 32'hB0);
    nxt();
    @(negedge clk);
    chk("t3_grant_m2", 32'(bus.grant_o), 32'h4);
    set_m(1, 1'b1, 1'b1, 32'h300, 32'hC1);
    #1;
    chk("t3_stall_m1", 32'(bus.m_stall_o), 32'hB);
    chk("t3_ack_m2", 32'(bus.m_ack_o), 32'h4);
    nxt();
    set_m(2, 1'b1, 1'b1, 32'h204, 32'hB1);
    @(negedge clk);
    chk("t3_hold1", 32'(bus.grant_o), 32'h4);
    chk("t3_sadr", bus.s_adr_o, 32'h204);
    nxt();
    set_m(2, 1'b1, 1'b1, 32'h208, 32'hB2);
    @(negedge clk);
    chk("t3_hold2", 32'(bus.grant_o), 32'h4);
    nxt();
    set_m(2, 1'b0, 1'b0, 32'h208, 32'hB2);
    @(negedge clk);
    chk("t3_drop_scyc", 32'(bus.s_cyc_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("t3_idle", 32'(bus.grant_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("t3_grant_m1", 32'(bus.grant_o), 32'h2);

    // m1 re-requests immediately while m3 is pending
    set_m(3, 1'b1, 1'b1, 32'h3F0, 32'hD3);
    nxt();
    set_m(1, 1'b0, 1'b0, 32'h300, 32'hC1);
    nxt();
    set_m(1, 1'b1, 1'b1, 32'h304, 32'hC2);
    @(negedge clk);
    chk("t4_idle", 32'(bus.grant_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("t4_grant_m3", 32'(bus.grant_o), 32'h8);
    ack_en  = 1'b0;
    slv_err = 1'b1;
    #1;
    chk("t4_err_fwd", 32'(bus.m_err_o), 32'h8);
    slv_err = 1'b0;
    ack_en  = 1'b1;
    nxt();
    set_m(3, 1'b0, 1'b0, 32'h3F0, 32'hD3);
    nxt();
    nxt();
    @(negedge clk);
    chk("t4_grant_m1", 32'(bus.grant_o), 32'h2);
    nxt();
    set_m(1, 1'b0, 1'b0, 32'h304, 32'hC2);
    nxt();
    chk("t3_mem0", mem[8'h80], 32'hB0);
    chk("t3_mem1", mem[8'h81], 32'hB1);
    chk("t3_mem2", mem[8'h82], 32'hB2);
    chk("t3_mem_m1", mem[8'hC0], 32'hC1);
    chk("t4_mem_m3", mem[8'hFC], 32'hD3);
    chk("t4_mem_m1", mem[8'hC1], 32'hC2);

    // async reset in the middle of an m2 write
    set_m(0, 1'b1, 1'b1, 32'h10, 32'hE0);
    set_m(2, 1'b1, 1'b1, 32'h20, 32'hE2);
    ack_en = 1'b0;
    nxt();
    @(negedge clk);
    chk("t5_grant_m2", 32'(bus.grant_o), 32'h4);
    chk("t5_scyc_on", 32'(bus.s_cyc_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("t5_scyc_off", 32'(bus.s_cyc_o), 32'h0);
    chk("t5_grant_clr", 32'(bus.grant_o), 32'h0);
    chk("t5_stall", 32'(bus.m_stall_o), 32'hF);
    nxt();
    rst    = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    chk("t5_idle", 32'(bus.grant_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("t5_grant_m0", 32'(bus.grant_o), 32'h1);
    nxt();
    set_m(0, 1'b0, 1'b0, 32'h10, 32'hE0);
    set_m(2, 1'b0, 1'b0, 32'h20, 32'hE2);
    nxt();
    chk("t5_mem_m0", mem[8'h04], 32'hE0);

`ifdef WB_ARB_TIMEOUT_EN
    // slave never answers: err after 16 strobe cycles
    ack_en = 1'b0;
    set_m(3, 1'b1, 1'b1, 32'h3E0, 32'hF3);
    nxt();
    for (int i = 0; i < 14; i++) nxt();
    @(negedge clk);
    chk("t6_no_err_c15", 32'(bus.m_err_o), 32'h0);
    nxt();
    @(negedge clk);
    chk("t6_err_c16", 32'(bus.m_err_o), 32'h8);
    nxt();
    @(negedge clk);
    chk("t6_stb_gated", 32'(bus.s_stb_o), 32'h0);
    chk("t6_err_pulse", 32'(bus.m_err_o), 32'h0);
    set_m(3, 1'b0, 1'b0, 32'h3E0, 32'hF3);
    ack_en = 1'b1;
    nxt();
    @(negedge clk);
    chk("t6_idle", 32'(bus.grant_o), 32'h0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
